// File: rtl/multiplicador_seq_8bits.sv
// -----------------------------------------------------------------------------
// multiplicador_seq_8bits
//
// Unsigned 8x8 -> 16 bit shift-and-add multiplier. A product is computed over
// several clock cycles, one multiplier bit per cycle, LSB first.
//
// Ports
//   clk    in   1   rising-edge clock for all state
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   multiply request, accepted only while idle
//   a      in   8   multiplicand (unsigned), latched when start is accepted
//   b      in   8   multiplier (unsigned), latched when start is accepted
//   busy   out  1   high while the multiplication is in progress (CALC)
//   done   out  1   one-cycle pulse: a new product is valid on p
//   p      out  16  product a*b, held until the next done
//
// Build option
//   MULT_EARLY_EXIT_EN  when defined, the computation stops as soon as no set
//                       multiplier bits remain; otherwise it always runs for
//                       8 steps. The product is the same in both builds.
// -----------------------------------------------------------------------------
module multiplicador_seq_8bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  b_reg, b_next;      // shifts right one bit per step
    logic [15:0] acc_reg, acc_next;
    logic [15:0] p_reg, p_next;
    logic [2:0]  cnt_reg, cnt_next;  // step index, doubles as the shift amount

    logic [7:0]  partial;
    logic [15:0] partial_shifted;
    logic [15:0] acc_sum;
    logic        last_step;

    // Partial product: multiplicand ANDed with the current multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_partial
            assign partial[gi] = a_reg[gi] & b_reg[0];
        end
    endgenerate

    assign partial_shifted = {8'd0, partial} << cnt_reg;
    assign acc_sum         = acc_reg + partial_shifted;

`ifdef MULT_EARLY_EXIT_EN
    // Once the bits left after this step's shift are all zero, the remaining
    // steps would only add zeros. The 8th step always leaves b_reg[7:1]==0.
    assign last_step = (b_reg[7:1] == 7'd0);
`else
    assign last_step = (cnt_reg == 3'd7);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= 8'd0;
            b_reg     <= 8'd0;
            acc_reg   <= 16'd0;
            p_reg     <= 16'd0;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    acc_next   = 16'd0;
                    cnt_next   = 3'd0;
                    state_next = CALC;
                end
            end

            CALC: begin
                acc_next = acc_sum;
                b_next   = {1'b0, b_reg[7:1]};
                cnt_next = cnt_reg + 3'd1;
                if (last_step) begin
                    // p takes the completed sum on the edge that enters DONE,
                    // so it never shows a partial result.
                    p_next     = acc_sum;
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == CALC);
    assign done = (state_reg == DONE);
    assign p    = p_reg;

endmodule

// File: tb/tb_multiplicador_seq_8bits.sv
// -----------------------------------------------------------------------------
// Testbench for multiplicador_seq_8bits.
// A transaction-level model (operation timeline + product) predicts busy, done
// and p every cycle; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_multiplicador_seq_8bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    multiplicador_seq_8bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Number of busy cycles an operation with multiplier bb takes.
    function automatic int op_len(input logic [7:0] bb);
`ifdef MULT_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 8; i++) if (bb[i]) hi = i;
        return hi + 1;
`else
        return 8;
`endif
    endfunction

    // m_phase: -1 idle, otherwise cycles since acceptance.
    // Busy for phases 0..len-1, done at phase len, then idle.
    int m_phase = -1;
    int m_len   = 8;
    int m_prod  = 0;
    int m_p     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= -1;
            m_p     <= 0;
        end else if (m_phase < 0) begin
            if (start) begin
                m_phase <= 0;
                m_prod  <= int'(a) * int'(b);
                m_len   <= op_len(b);
            end
        end else begin
            if (m_phase + 1 == m_len) m_p <= m_prod;
            m_phase <= (m_phase == m_len) ? -1 : m_phase + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", 32'(busy), 32'(m_phase >= 0 && m_phase < m_len));
            chk("model_done", 32'(done), 32'(m_phase == m_len));
            chk("model_p",    32'(p),    32'(m_p[15:0]));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp_p, input int exp_busy, input string nm);
        int busy_cnt;
        bit seen;
        logic [15:0] p_before;
        busy_cnt = 0;
        seen = 0;
        @(posedge clk); #1;
        p_before = p;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);   // must not disturb the running op
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                chk({nm, "_p_hold"}, 32'(p), 32'(p_before));
            end
            if (done) seen = 1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk({nm, "_p"}, 32'(p), 32'(exp_p));
        $display("op %s: a=%02h b=%02h p=%04h busy_cycles=%0d", nm, ta, tb_v, p, busy_cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_cnt;
        int last_done;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p",    32'(p),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Hand-computed products
        run_op(8'hFF, 8'hFF, 16'hFE01, 8, "ff_x_ff");
`ifdef MULT_EARLY_EXIT_EN
        run_op(8'h0F, 8'h10, 16'h00F0, 5, "0f_x_10");
        run_op(8'hAB, 8'h00, 16'h0000, 1, "ab_x_00");
`else
        run_op(8'h0F, 8'h10, 16'h00F0, 8, "0f_x_10");
        run_op(8'hAB, 8'h00, 16'h0000, 8, "ab_x_00");
`endif

        // Start during busy must be ignored
        @(posedge clk); #1;
        a = 8'h03; b = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 8'h07; b = 8'h07; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("ignore_start_p", 32'(p), 32'h000F);
            end
        end
        chk("ignore_start_done_count", 32'(done_cnt), 32'd1);
        $display("op ignore_start: dones=%0d p=%04h", done_cnt, p);

        // Reset on the 4th CALC cycle aborts the operation
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;              // first CALC cycle
        start = 1'b0;
        repeat (3) @(posedge clk);       // fourth CALC cycle
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p",    32'(p),    32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        $display("op abort: busy=%0b done=%0b p=%04h", busy, done, p);
`ifdef MULT_EARLY_EXIT_EN
        run_op(8'h12, 8'h34, 16'h03A8, 6, "12_x_34");
`else
        run_op(8'h12, 8'h34, 16'h03A8, 8, "12_x_34");
`endif

        // Start held high: one result per 10 cycles (8-step build) or len+2
        @(posedge clk); #1;
        a = 8'h02; b = 8'h03; start = 1'b1;
        done_cnt = 0;
        last_done = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("held_start_p", 32'(p), 32'h0006);
                if (last_done >= 0) begin
`ifdef MULT_EARLY_EXIT_EN
                    chk("held_start_period", 32'(cyc - last_done), 32'd4);
`else
                    chk("held_start_period", 32'(cyc - last_done), 32'd10);
`endif
                end
                last_done = cyc;
                $display("op held_start: done at cycle %0d p=%04h", cyc, p);
            end
        end
        start = 1'b0;
        chk("held_start_min_dones", 32'(done_cnt >= 3), 32'd1);

        // Randomized traffic including mid-operation resets
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                $display("rand: reset asserted at cycle %0d", cyc);
            end else begin
                rst_n = 1'b1;
            end
            start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'(1 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
